// File: rtl/dp_pkg.sv
// Shared types and constants for the data plane receive path.
package dp_pkg;

  localparam int PKT_W         = 32;
  localparam int DP_DATA_WORDS = 4;

  typedef struct packed {
    logic [15:0] dest;
    logic [15:0] payload;
  } dp_packet_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } dp_rx_state_t;

  function automatic logic dest_match(input dp_packet_t pkt, input logic [15:0] id);
    return (pkt.dest == id);
  endfunction

endpackage

// File: rtl/rx_frame_buffer.sv
// Circular word buffer with a speculative write pointer: frames are written
// ahead of the committed pointer and either committed whole or rewound.
module rx_frame_buffer #(
  parameter int DEPTH = 32,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [15:0]   wr_data_i,
  input  logic          commit_i,
  input  logic          rewind_i,
  input  logic          pop_i,
  output logic [15:0]   head_o,
  output logic [PW-1:0] count_o,
  output logic [PW-1:0] free_o
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
  localparam logic [PW-1:0] PTR_CAP = PW'(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] spec_wr_q, spec_wr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic [15:0]   head_q, head_d;
  logic          pop_ok_s;

  assign count_o = count_q;
  assign head_o  = head_q;
  assign free_o  = PTR_CAP - (spec_wr_q - rd_ptr_q);

  // Pointer next-state; the head word is prefetched so it is stable while presented.
  always_comb begin
    pop_ok_s = pop_i && (count_q != {PW{1'b0}});
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (rewind_i) begin
      spec_wr_d = wr_ptr_q;
    end else if (wr_en_i) begin
      spec_wr_d = spec_wr_q + PTR_ONE;
    end else begin
      spec_wr_d = spec_wr_q;
    end
    if (commit_i) begin
      wr_ptr_d = spec_wr_d;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    count_d = wr_ptr_d - rd_ptr_d;
    // The head slot is always committed, so it is never the slot being written this cycle.
    if (count_d == {PW{1'b0}}) begin
      head_d = 16'h0000;
    end else begin
      head_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= {PW{1'b0}};
      spec_wr_q <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      count_q   <= {PW{1'b0}};
      head_q    <= 16'h0000;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      spec_wr_q <= spec_wr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      head_q    <= head_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[spec_wr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/data_plane_rx.sv
// Data plane receiver: frame detection FSM in front of a commit/rewind RX buffer.
module data_plane_rx
  import dp_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int DATA_WORDS = DP_DATA_WORDS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              node_id,
  input  logic [PKT_W-1:0]         data_rx_packet,
  input  logic                     gpp_rd_rx,
  output logic [15:0]              RAM_rx_data_out,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     rx_busy,
  output logic                     rx_frame_done,
  output logic                     rx_error,
  output logic                     rx_drop
);

  localparam int            PW        = $clog2(DEPTH) + 1;
  localparam int            CW        = $clog2(DATA_WORDS + 1);
  localparam logic [PW-1:0] FRAME_LEN = PW'(DATA_WORDS + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(DATA_WORDS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);

  dp_packet_t    pkt_s;
  dp_rx_state_t  state_q;
  logic [CW-1:0] word_cnt_q;
  logic          busy_q, done_q, error_q, drop_q;
  logic          hit_s, room_s, last_s;
  logic          wr_en_s, commit_s, rewind_s;
  logic [PW-1:0] free_s;

  assign pkt_s         = dp_packet_t'(data_rx_packet);
  assign hit_s         = dest_match(pkt_s, node_id);
  assign room_s        = (free_s >= FRAME_LEN);
  assign last_s        = (word_cnt_q == LAST_IDX);
  assign rx_busy       = busy_q;
  assign rx_frame_done = done_q;
  assign rx_error      = error_q;
  assign rx_drop       = drop_q;

  // Buffer control decoded from the current state and the sampled packet.
  always_comb begin
    wr_en_s  = 1'b0;
    commit_s = 1'b0;
    rewind_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit_s && room_s) begin
          wr_en_s = 1'b1;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      RECV: begin
        if (hit_s) begin
          wr_en_s  = 1'b1;
          commit_s = last_s;
        end else begin
          rewind_s = 1'b1;
        end
      end
      DROP:    wr_en_s = 1'b0;
      default: wr_en_s = 1'b0;
    endcase
  end

  // Frame FSM with registered busy flag and single-cycle event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_cnt_q <= {CW{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      drop_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hit_s) begin
            word_cnt_q <= {CW{1'b0}};
            busy_q     <= 1'b1;
            if (room_s) begin
              state_q <= RECV;
            end else begin
              state_q <= DROP;
              drop_q  <= 1'b1;
            end
          end
        end
        RECV, DROP: begin
          if (!hit_s) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
            word_cnt_q <= {CW{1'b0}};
          end else if (last_s) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= (state_q == RECV);
            word_cnt_q <= {CW{1'b0}};
          end else begin
            word_cnt_q <= word_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          word_cnt_q <= {CW{1'b0}};
        end
      endcase
    end
  end

  rx_frame_buffer #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en_s),
    .wr_data_i (pkt_s.payload),
    .commit_i  (commit_s),
    .rewind_i  (rewind_s),
    .pop_i     (gpp_rd_rx),
    .head_o    (RAM_rx_data_out),
    .count_o   (rx_count),
    .free_o    (free_s)
  );

endmodule

// File: tb/tb_data_plane_rx.sv
// Drives two receivers (DEPTH 32 and DEPTH 8) with one packet stream and
// checks both against a queue-based frame model plus a pop-data scoreboard.
module tb_data_plane_rx;

  localparam logic [15:0] NODE = 16'h0005;
  localparam int          NW   = 4;

  logic        clk;
  logic        rst;
  logic [15:0] node_id;
  logic [31:0] data_rx_packet;
  logic        gpp_rd_rx;
  logic [15:0] head [2];
  logic [5:0]  cnt32;
  logic [3:0]  cnt8;
  logic        busy [2];
  logic        done [2];
  logic        err  [2];
  logic        drop [2];

  data_plane_rx #(.DEPTH(32), .DATA_WORDS(NW)) dut32 (
    .clk(clk), .rst(rst), .node_id(node_id), .data_rx_packet(data_rx_packet),
    .gpp_rd_rx(gpp_rd_rx), .RAM_rx_data_out(head[0]), .rx_count(cnt32),
    .rx_busy(busy[0]), .rx_frame_done(done[0]), .rx_error(err[0]), .rx_drop(drop[0]));

  data_plane_rx #(.DEPTH(8), .DATA_WORDS(NW)) dut8 (
    .clk(clk), .rst(rst), .node_id(node_id), .data_rx_packet(data_rx_packet),
    .gpp_rd_rx(gpp_rd_rx), .RAM_rx_data_out(head[1]), .rx_count(cnt8),
    .rx_busy(busy[1]), .rx_frame_done(done[1]), .rx_error(err[1]), .rx_drop(drop[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: committed words, words of the frame in flight, frame mode.
  int          dep [2] = '{32, 8};
  logic [15:0] com_q  [2][$];
  logic [15:0] pend_q [2][$];
  logic [15:0] exp_q  [2][$];
  int          m_mode [2];   // 0 idle, 1 receiving, 2 dropping
  int          m_cnt  [2];
  int          m_done [2];
  int          m_err  [2];
  int          m_drop [2];
  bit          just_reset;
  logic [31:0] prev_pkt;
  logic        prev_pop;
  logic        prev_rst;
  int          n_pass;
  int          n_checks;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step(input int d, input logic [31:0] pkt, input logic pop, input logic r);
    int   free;
    logic hit;
    if (r) begin
      com_q[d].delete();
      pend_q[d].delete();
      m_mode[d] = 0; m_cnt[d] = 0;
      m_done[d] = 0; m_err[d] = 0; m_drop[d] = 0;
    end else begin
      free = dep[d] - com_q[d].size() - pend_q[d].size();
      hit  = (pkt[31:16] == NODE);
      m_done[d] = 0; m_err[d] = 0; m_drop[d] = 0;
      if (pop && com_q[d].size() > 0) void'(com_q[d].pop_front());
      case (m_mode[d])
        0: if (hit) begin
          m_cnt[d] = 0;
          if (free >= NW + 1) begin
            pend_q[d].push_back(pkt[15:0]);
            m_mode[d] = 1;
          end else begin
            m_drop[d] = 1;
            m_mode[d] = 2;
          end
        end
        1: if (hit) begin
          pend_q[d].push_back(pkt[15:0]);
          if (pend_q[d].size() == NW + 1) begin
            for (int i = 0; i < pend_q[d].size(); i++) com_q[d].push_back(pend_q[d][i]);
            pend_q[d].delete();
            m_done[d] = 1;
            m_mode[d] = 0;
          end
        end else begin
          pend_q[d].delete();
          m_err[d]  = 1;
          m_mode[d] = 0;
        end
        2: if (hit) begin
          m_cnt[d]++;
          if (m_cnt[d] == NW) m_mode[d] = 0;
        end else begin
          m_err[d]  = 1;
          m_mode[d] = 0;
        end
        default: m_mode[d] = 0;
      endcase
    end
  endtask

  // One bus cycle: settle the model for the edge just taken, then drive the next inputs.
  task automatic step(input logic [31:0] pkt, input logic pop, input logic r);
    @(negedge clk);
    for (int d = 0; d < 2; d++) model_step(d, prev_pkt, prev_pop, prev_rst);
    just_reset     = prev_rst;
    rst            = r;
    data_rx_packet = pkt;
    gpp_rd_rx      = pop;
    prev_pkt = pkt; prev_pop = pop; prev_rst = r;
    if (!r && pop) begin
      for (int d = 0; d < 2; d++)
        if (com_q[d].size() > 0) exp_q[d].push_back(com_q[d][0]);
    end
  endtask

  task automatic frame(input logic [15:0] dest, input logic [15:0] src, input int n,
                       input logic [15:0] base, input int pm);
    step({dest, src}, (pm == 1) && ($urandom_range(0, 2) == 0), 1'b0);
    for (int i = 0; i < n; i++) begin
      logic [15:0] pl;
      logic        p;
      pl = (base == 16'h0000) ? 16'($urandom) : base + 16'(i + 1);
      p  = (pm == 1) ? ($urandom_range(0, 2) == 0) : ((pm == 2) && (i == n - 1));
      step({dest, pl}, p, 1'b0);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 1'b1, 1'b0);
  endtask

  // Monitor: status against the model every cycle, head word against the scoreboard on pops.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("count32", int'(cnt32), com_q[0].size());
      chk("count8", int'(cnt8), com_q[1].size());
      for (int d = 0; d < 2; d++) begin
        chk("busy", int'(busy[d]), int'(m_mode[d] != 0));
        chk("frame_done", int'(done[d]), m_done[d]);
        chk("error", int'(err[d]), m_err[d]);
        chk("drop", int'(drop[d]), m_drop[d]);
        if (just_reset) chk("head_after_reset", int'(head[d]), 0);
      end
      if (gpp_rd_rx && !rst) begin
        if (cnt32 != 6'd0) begin
          if (exp_q[0].size() == 0) chk("pop_unexpected32", 1, 0);
          else chk("pop_data32", int'(head[0]), int'(exp_q[0].pop_front()));
        end
        if (cnt8 != 4'd0) begin
          if (exp_q[1].size() == 0) chk("pop_unexpected8", 1, 0);
          else chk("pop_data8", int'(head[1]), int'(exp_q[1].pop_front()));
        end
      end
    end
  end

  initial begin
    node_id = NODE;
    rst = 1'b1; data_rx_packet = 32'h0; gpp_rd_rx = 1'b0;
    prev_pkt = 32'h0; prev_pop = 1'b0; prev_rst = 1'b1;
    n_pass = 0; n_checks = 0;
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_cnt[d] = 0; m_done[d] = 0; m_err[d] = 0; m_drop[d] = 0;
    end
    repeat (3) step(32'h0, 1'b0, 1'b1);
    // Basic frame and readback.
    frame(NODE, 16'h0009, NW, 16'hAAA0, 0);
    step(32'h0, 1'b0, 1'b0);
    drain(5);
    // Frame to another node.
    frame(16'h0007, 16'h0001, NW, 16'h0000, 0);
    step(32'h0, 1'b0, 1'b0);
    // Aborted frame, then a clean frame from the rewound pointer.
    frame(NODE, 16'h0011, 2, 16'h0000, 0);
    step(32'h0, 1'b0, 1'b0);
    frame(NODE, 16'h0012, NW, 16'h0000, 0);
    step(32'h0, 1'b0, 1'b0);
    drain(5);
    // Fill the small buffer, get a drop, drain, then accept again.
    frame(NODE, 16'h0021, NW, 16'h0000, 0);
    frame(NODE, 16'h0022, NW, 16'h0000, 0);
    step(32'h0, 1'b0, 1'b0);
    drain(10);
    frame(NODE, 16'h0023, NW, 16'h0000, 0);
    step(32'h0, 1'b0, 1'b0);
    drain(5);
    // Back-to-back frames with a pop on the second commit edge.
    frame(NODE, 16'h0031, NW, 16'h0000, 0);
    frame(NODE, 16'h0032, NW, 16'h0000, 2);
    step(32'h0, 1'b0, 1'b0);
    drain(10);
    // Reset in the middle of a frame, then pops on an empty buffer.
    frame(NODE, 16'h0041, 1, 16'h0000, 0);
    step({NODE, 16'h1234}, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b0);
    drain(2);
    // Randomized traffic.
    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        frame(NODE, 16'($urandom_range(1, 65535)), NW, 16'h0000, 1);
      end else if (r == 6) begin
        frame(16'($urandom_range(6, 40)), 16'h0001, NW, 16'h0000, 1);
      end else if (r == 7) begin
        frame(NODE, 16'h0002, $urandom_range(0, 3), 16'h0000, 1);
        if ($urandom_range(0, 1) == 0) step(32'h0, 1'b0, 1'b0);
        else step({16'h0009, 16'($urandom)}, 1'b0, 1'b0);
      end else if (r == 8) begin
        for (int k = 0; k < 3; k++) step(32'h0, ($urandom_range(0, 1) == 1), 1'b0);
      end else begin
        drain($urandom_range(1, 8));
      end
    end
    drain(40);
    repeat (3) step(32'h0, 1'b0, 1'b0);
    #4;
    chk("scoreboard_empty32", exp_q[0].size(), 0);
    chk("scoreboard_empty8", exp_q[1].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
